// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multi-cycle RV32I load/store unit with req/ack bus handshake
// Optional bus-wait abort is compiled in when LSU_TIMEOUT_EN is defined.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              Bus_req,
  input  logic              Bus_ack,
  output logic [ADDR_W-1:0] Bus_addr,
  output logic              Bus_wen,
  output logic [3:0]        Bus_wmask,
  output logic [31:0]       Bus_wdata,
  input  logic [31:0]       Bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, err_q;
  logic [2:0]        f3_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        mask_q;
  logic [31:0]       wdata_q, rdata_q;

  logic        legal, aligned, accept, reject, ack_take, timeout_hit;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata, shifted, load_ext;

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_we;
      default:                legal = 1'b0;
    endcase
    aligned = !((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00));

    case (req_funct3[1:0])
      2'b00: begin
        lane_wdata = {4{req_wdata[7:0]}};
        lane_mask  = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{req_wdata[15:0]}};
        lane_mask  = 4'b0011 << req_addr[1:0];
      end
      default: begin
        lane_wdata = req_wdata;
        lane_mask  = 4'b1111;
      end
    endcase
  end

  // Bring the addressed byte/half down to bit 0, then extend by access type.
  always_comb begin
    shifted = Bus_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'b0, shifted[7:0]};
      3'b101:  load_ext = {16'b0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst || accept) cnt_q <= '0;
    else if (state_q == BUS) cnt_q <= cnt_q + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    reject      = 1'b0;
    ack_take    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (legal && aligned) begin
            accept  = 1'b1;
            state_d = BUS;
          end else begin
            reject  = 1'b1;
            state_d = DONE;
          end
        end
      end
      BUS: begin
        if (Bus_ack) begin
          ack_take = 1'b1;
          state_d  = DONE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      lane_q  <= 2'b0;
      addr_q  <= '0;
      mask_q  <= 4'b0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        lane_q  <= req_addr[1:0];
        addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
        mask_q  <= lane_mask;
        wdata_q <= lane_wdata;
        rdata_q <= 32'b0;
        err_q   <= 1'b0;
      end
      if (reject || timeout_hit) begin
        rdata_q <= 32'b0;
        err_q   <= 1'b1;
      end
      if (ack_take) begin
        rdata_q <= we_q ? 32'b0 : load_ext;
        err_q   <= 1'b0;
      end
    end
  end

  assign Bus_req   = (state_q == BUS);
  assign Bus_wen   = Bus_req & we_q;
  assign Bus_addr  = addr_q;
  assign Bus_wmask = mask_q;
  assign Bus_wdata = wdata_q;
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign stall     = req_valid & (state_q != DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
// Timeout scenarios are exercised when LSU_TIMEOUT_EN is defined.
module tb_mem_access_unit;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
  logic        stall, rsp_valid, rsp_err, Bus_req, Bus_wen;
  logic        Bus_ack = 1'b0;
  logic [31:0] rsp_rdata, Bus_addr, Bus_wdata;
  logic [31:0] Bus_rdata = 32'b0;
  logic [3:0]  Bus_wmask;

  int n_checks = 0;
  int n_fail = 0;

  int          o_req_cnt, o_stall_cnt, o_rsp_cyc, o_ack_cyc;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_mask;
  logic        o_err, o_wen, o_unstable;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Bus_req(Bus_req), .Bus_ack(Bus_ack), .Bus_addr(Bus_addr), .Bus_wen(Bus_wen),
    .Bus_wmask(Bus_wmask), .Bus_wdata(Bus_wdata), .Bus_rdata(Bus_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Entered 1 time unit after a rising edge; returns 1 unit after the edge leaving DONE.
  // ack_after = number of BUS cycles without ack before the ack cycle (-1: never ack).
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdata, input int ack_after);
    int cyc = 0;
    int seen = 0;
    o_req_cnt = 0; o_stall_cnt = 0; o_rsp_cyc = -1; o_ack_cyc = -1;
    o_rdata = 32'hx; o_err = 1'bx; o_unstable = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    Bus_rdata = rdata;
    while (cyc < 60) begin
      #1;
      if (stall) o_stall_cnt++;
      if (Bus_req) begin
        o_req_cnt++;
        seen++;
        if (seen == 1) begin
          o_addr = Bus_addr; o_mask = Bus_wmask; o_wdata = Bus_wdata; o_wen = Bus_wen;
        end else if (Bus_addr !== o_addr || Bus_wmask !== o_mask || Bus_wdata !== o_wdata)
          o_unstable = 1'b1;
        if (ack_after >= 0 && seen == ack_after + 1) begin
          Bus_ack = 1'b1;
          o_ack_cyc = cyc;
        end
      end
      if (rsp_valid) begin
        o_rsp_cyc = cyc; o_rdata = rsp_rdata; o_err = rsp_err;
      end
      @(posedge cpu_clk); #1;
      Bus_ack = 1'b0;
      cyc++;
      if (o_rsp_cyc >= 0) break;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    cpu_rst = 1'b0;
    repeat (2) @(posedge cpu_clk);
    #1;
    n_checks++; if (Bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req got %b exp 0", Bus_req); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_checks++; if ({rsp_err, rsp_rdata} !== 33'b0) begin n_fail++; $display("FAIL reset_rsp got %b/%h exp 0/0", rsp_err, rsp_rdata); end
    n_checks++; if ({Bus_wen, Bus_wmask, Bus_addr, Bus_wdata} !== 69'b0) begin n_fail++; $display("FAIL reset_bus_out got wen=%b mask=%b addr=%h wdata=%h exp 0", Bus_wen, Bus_wmask, Bus_addr, Bus_wdata); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
    cpu_rst = 1'b1;
    @(posedge cpu_clk); #1;
  endtask

  task automatic test_stores;
    run_access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 2);
    n_checks++; if (o_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_addr got %h exp 00001000", o_addr); end
    n_checks++; if (o_mask !== 4'b1000) begin n_fail++; $display("FAIL sb_mask got %b exp 1000", o_mask); end
    n_checks++; if (o_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata got %h exp a5a5a5a5", o_wdata); end
    n_checks++; if (o_wen !== 1'b1) begin n_fail++; $display("FAIL sb_wen got %b exp 1", o_wen); end
    n_checks++; if (o_rsp_cyc !== o_ack_cyc + 1 || o_ack_cyc !== 3) begin n_fail++; $display("FAIL sb_latency got ack=%0d rsp=%0d exp 3/4", o_ack_cyc, o_rsp_cyc); end
    n_checks++; if (o_req_cnt !== 3 || o_stall_cnt !== 4) begin n_fail++; $display("FAIL sb_counts got req=%0d stall=%0d exp 3/4", o_req_cnt, o_stall_cnt); end
    n_checks++; if (o_err !== 1'b0 || o_unstable !== 1'b0) begin n_fail++; $display("FAIL sb_err_stable got err=%b unstable=%b exp 0/0", o_err, o_unstable); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sb_rsp_pulse got %b exp 0", rsp_valid); end

    run_access(1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 32'h0, 0);
    n_checks++; if (o_mask !== 4'b1100 || o_wdata !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_lanes got mask=%b wdata=%h exp 1100/beefbeef", o_mask, o_wdata); end

    run_access(1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 1);
    n_checks++; if (o_mask !== 4'b1111 || o_wdata !== 32'hDEAD_BEEF || o_addr !== 32'h0000_1004) begin n_fail++; $display("FAIL sw_lanes got mask=%b wdata=%h addr=%h exp 1111/deadbeef/00001004", o_mask, o_wdata, o_addr); end
  endtask

  task automatic test_loads;
    run_access(1'b0, 3'b000, 32'h0000_2002, 32'h0, 32'h12F0_3456, 1);
    n_checks++; if (o_rdata !== 32'hFFFF_FFF0 || o_err !== 1'b0) begin n_fail++; $display("FAIL lb got %h err=%b exp fffffff0/0", o_rdata, o_err); end
    n_checks++; if (o_wen !== 1'b0 || o_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL lb_bus got wen=%b addr=%h exp 0/00002000", o_wen, o_addr); end
    run_access(1'b0, 3'b100, 32'h0000_2002, 32'h0, 32'h12F0_3456, 0);
    n_checks++; if (o_rdata !== 32'h0000_00F0) begin n_fail++; $display("FAIL lbu got %h exp 000000f0", o_rdata); end
    run_access(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 0);
    n_checks++; if (o_rdata !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh got %h exp ffff8001", o_rdata); end
    run_access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000, 0);
    n_checks++; if (o_rdata !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu got %h exp 00008001", o_rdata); end
    run_access(1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h12F0_3456, 0);
    n_checks++; if (o_rdata !== 32'h12F0_3456) begin n_fail++; $display("FAIL lw got %h exp 12f03456", o_rdata); end
    run_access(1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_7F00, 0);
    n_checks++; if (o_rdata !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_pos got %h exp 0000007f", o_rdata); end
  endtask

  task automatic test_errors;
    run_access(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'hFFFF_FFFF, -1);
    n_checks++; if (o_req_cnt !== 0) begin n_fail++; $display("FAIL mis_lw_bus_req got %0d exp 0", o_req_cnt); end
    n_checks++; if (o_rsp_cyc !== 1 || o_err !== 1'b1 || o_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_lw_rsp got cyc=%0d err=%b rdata=%h exp 1/1/0", o_rsp_cyc, o_err, o_rdata); end
    n_checks++; if (o_stall_cnt !== 1) begin n_fail++; $display("FAIL mis_lw_stall got %0d exp 1", o_stall_cnt); end
    run_access(1'b0, 3'b001, 32'h0000_2003, 32'h0, 32'h0, -1);
    n_checks++; if (o_err !== 1'b1 || o_req_cnt !== 0) begin n_fail++; $display("FAIL mis_lh got err=%b req=%0d exp 1/0", o_err, o_req_cnt); end
    run_access(1'b1, 3'b100, 32'h0000_1000, 32'h1, 32'h0, -1);
    n_checks++; if (o_err !== 1'b1 || o_req_cnt !== 0) begin n_fail++; $display("FAIL illegal_store got err=%b req=%0d exp 1/0", o_err, o_req_cnt); end
    run_access(1'b0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, -1);
    n_checks++; if (o_err !== 1'b1 || o_req_cnt !== 0) begin n_fail++; $display("FAIL illegal_load got err=%b req=%0d exp 1/0", o_err, o_req_cnt); end
  endtask

  task automatic test_back_to_back;
    run_access(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'hCAFE_0001, 0);
    n_checks++; if (o_rsp_cyc !== 2 || o_stall_cnt !== 2 || o_rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL b2b_first got cyc=%0d stall=%0d rdata=%h exp 2/2/cafe0001", o_rsp_cyc, o_stall_cnt, o_rdata); end
    run_access(1'b0, 3'b010, 32'h0000_4004, 32'h0, 32'hCAFE_0002, 0);
    n_checks++; if (o_rsp_cyc !== 2 || o_rdata !== 32'hCAFE_0002 || o_addr !== 32'h0000_4004) begin n_fail++; $display("FAIL b2b_second got cyc=%0d rdata=%h addr=%h exp 2/cafe0002/00004004", o_rsp_cyc, o_rdata, o_addr); end
  endtask

  task automatic test_timeout;
`ifdef LSU_TIMEOUT_EN
    run_access(1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h1111_1111, -1);
    n_checks++; if (o_req_cnt !== 4 || o_rsp_cyc !== 5) begin n_fail++; $display("FAIL timeout_cycles got req=%0d rsp=%0d exp 4/5", o_req_cnt, o_rsp_cyc); end
    n_checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_err got err=%b rdata=%h exp 1/0", o_err, o_rdata); end
    Bus_ack = 1'b1;
    @(posedge cpu_clk); #1;
    Bus_ack = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || Bus_req !== 1'b0) begin n_fail++; $display("FAIL timeout_late_ack got rsp=%b req=%b exp 0/0", rsp_valid, Bus_req); end
    run_access(1'b0, 3'b010, 32'h0000_5004, 32'h0, 32'h2222_2222, 3);
    n_checks++; if (o_err !== 1'b0 || o_rdata !== 32'h2222_2222 || o_rsp_cyc !== 5) begin n_fail++; $display("FAIL timeout_ack_wins got err=%b rdata=%h cyc=%0d exp 0/22222222/5", o_err, o_rdata, o_rsp_cyc); end
`else
    run_access(1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h3333_3333, 20);
    n_checks++; if (o_req_cnt !== 21 || o_err !== 1'b0 || o_rdata !== 32'h3333_3333) begin n_fail++; $display("FAIL long_wait got req=%0d err=%b rdata=%h exp 21/0/33333333", o_req_cnt, o_err, o_rdata); end
`endif
  endtask

  task automatic test_reset_mid_access;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_6000; req_wdata = 32'h5555_AAAA;
    repeat (2) begin @(posedge cpu_clk); #1; end
    n_checks++; if (Bus_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_bus got %b exp 1", Bus_req); end
    cpu_rst = 1'b0;
    @(posedge cpu_clk); #1;
    n_checks++; if (Bus_req !== 1'b0 || Bus_wen !== 1'b0) begin n_fail++; $display("FAIL rstmid_bus_req got req=%b wen=%b exp 0/0", Bus_req, Bus_wen); end
    n_checks++; if ({Bus_wmask, Bus_addr, Bus_wdata, rsp_valid, rsp_err, rsp_rdata} !== 102'b0) begin n_fail++; $display("FAIL rstmid_outputs got mask=%b addr=%h wdata=%h rsp=%b err=%b rdata=%h exp 0", Bus_wmask, Bus_addr, Bus_wdata, rsp_valid, rsp_err, rsp_rdata); end
    req_valid = 1'b0; cpu_rst = 1'b1; Bus_ack = 1'b1;
    @(posedge cpu_clk); #1;
    Bus_ack = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || Bus_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_stray_ack got rsp=%b req=%b exp 0/0", rsp_valid, Bus_req); end
    run_access(1'b1, 3'b010, 32'h0000_6008, 32'h0BAD_F00D, 32'h0, 1);
    n_checks++; if (o_err !== 1'b0 || o_mask !== 4'b1111 || o_wdata !== 32'h0BAD_F00D || o_addr !== 32'h0000_6008 || o_rsp_cyc !== 3) begin n_fail++; $display("FAIL rstmid_fresh_sw got err=%b mask=%b wdata=%h addr=%h cyc=%0d exp 0/1111/0badf00d/00006008/3", o_err, o_mask, o_wdata, o_addr, o_rsp_cyc); end
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_errors();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
